// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module   : cla_pipe_adder
//  Purpose  : Pipelined carry-lookahead adder/subtractor with valid/ready
//             handshakes on both sides. The operand is split into
//             STAGES = WIDTH/BLOCK slices. Each pipeline stage resolves one
//             BLOCK-bit slice with a lookahead unit and hands its carry to
//             the next stage through a register.
//  Ports    : clk         - clock, rising edge
//             rst_n       - synchronous, active-low reset
//             in_valid    - operand set present
//             in_ready    - operand set accepted this cycle
//             a, b        - operands (WIDTH bits)
//             carry_start - carry into bit 0 (ignored when sub=1)
//             sub         - 0: a+b+carry_start, 1: a-b (a+~b+1)
//             out_valid   - result present
//             out_ready   - downstream takes the result
//             sum         - result modulo 2^WIDTH
//             carry_out   - carry out of the MSB (1 = no borrow for sub)
//             overflow    - signed overflow, only when CLA_OVF_EN is defined
//  Options  : `define CLA_OVF_EN adds the overflow port and its register.
//  Revision : 1.0 - initial release
// ============================================================================
module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_start,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef CLA_OVF_EN
    ,
    output logic             overflow
`endif
);

    // WIDTH must be an integer multiple of BLOCK.
    localparam int c_stages = WIDTH / BLOCK;

    // BLOCK-bit lookahead unit. Every carry is formed directly from the
    // generate/propagate terms and the block carry-in (sum-of-products form),
    // not by rippling through the lower carries. Returns {carry_out, sum}.
    function automatic logic [BLOCK:0] f_cla(
        input logic [BLOCK-1:0] x,
        input logic [BLOCK-1:0] y,
        input logic             cin
    );
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] g;
        logic [BLOCK:0]   c;
        logic             pp;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]cin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (g[j] & pp);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & cin);
        end
        return {c[BLOCK], p ^ c[BLOCK-1:0]};
    endfunction

    // Per-stage inputs: index k is what stage k consumes. Index 0 comes from
    // the ports; index k>0 comes from the registers of stage k-1.
    logic                w_vld_in  [c_stages];
    logic [WIDTH-1:0]    w_word_in [c_stages];  // finished sum bits below, raw a above
    logic [WIDTH-1:0]    w_bop_in  [c_stages];  // b, already inverted for subtraction
    logic                w_cin     [c_stages];
    logic [c_stages-1:0] w_stage_vld;
    logic [c_stages-1:0] w_adv;

    logic [WIDTH-1:0]    w_sum_q;
    logic                w_cout_q;
    logic                w_vld_q;
`ifdef CLA_OVF_EN
    logic                w_ovf_q;
`endif

    // Subtraction is folded in at the pipeline entry as a + ~b + 1.
    assign w_vld_in[0]  = in_valid;
    assign w_word_in[0] = a;
    assign w_bop_in[0]  = sub ? ~b : b;
    assign w_cin[0]     = sub | carry_start;

    // Advance chain, resolved from the output backwards in one block so that
    // an empty stage anywhere lets everything upstream of it move (bubbles
    // collapse).
    always_comb begin
        logic w_adv_k;
        w_adv   = '0;
        w_adv_k = ~w_stage_vld[c_stages-1] | out_ready;
        w_adv[c_stages-1] = w_adv_k;
        for (int k = c_stages - 2; k >= 0; k--) begin
            w_adv_k  = ~w_stage_vld[k] | w_adv_k;
            w_adv[k] = w_adv_k;
        end
    end

    for (genvar k = 0; k < c_stages; k++) begin : g_stage
        logic [BLOCK:0]   w_blk;
        logic [WIDTH-1:0] w_word_nxt;
        logic             w_load;
        logic             r_vld;

        assign w_blk = f_cla(w_word_in[k][k*BLOCK +: BLOCK],
                             w_bop_in[k][k*BLOCK +: BLOCK],
                             w_cin[k]);

        // Data registers only load when a real operation moves in, so the
        // operand ports are don't-care on cycles without an accept.
        assign w_load = w_adv[k] & w_vld_in[k];

        always_comb begin
            w_word_nxt = w_word_in[k];
            w_word_nxt[k*BLOCK +: BLOCK] = w_blk[BLOCK-1:0];
        end

        assign w_stage_vld[k] = r_vld;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
            end else if (w_adv[k]) begin
                r_vld <= w_vld_in[k];
            end
        end

        if (k < c_stages - 1) begin : g_mid
            logic [WIDTH-1:0] r_word;
            logic [WIDTH-1:0] r_bop;
            logic             r_carry;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_word  <= '0;
                    r_bop   <= '0;
                    r_carry <= 1'b0;
                end else if (w_load) begin
                    r_word  <= w_word_nxt;
                    r_bop   <= w_bop_in[k];
                    r_carry <= w_blk[BLOCK];
                end
            end

            assign w_vld_in[k+1]  = r_vld;
            assign w_word_in[k+1] = r_word;
            assign w_bop_in[k+1]  = r_bop;
            assign w_cin[k+1]     = r_carry;
        end else begin : g_last
            logic [WIDTH-1:0] r_sum;
            logic             r_cout;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_sum  <= '0;
                    r_cout <= 1'b0;
                end else if (w_load) begin
                    r_sum  <= w_word_nxt;
                    r_cout <= w_blk[BLOCK];
                end
            end

            assign w_sum_q  = r_sum;
            assign w_cout_q = r_cout;
            assign w_vld_q  = r_vld;

`ifdef CLA_OVF_EN
            // Carry into the MSB is recovered as a^b^sum at that bit.
            logic w_ovf;
            logic r_ovf;

            assign w_ovf = w_blk[BLOCK] ^ (w_word_in[k][WIDTH-1] ^
                                           w_bop_in[k][WIDTH-1] ^
                                           w_blk[BLOCK-1]);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_load) begin
                    r_ovf <= w_ovf;
                end
            end

            assign w_ovf_q = r_ovf;
`endif
        end
    end

    // Outputs are forced quiet for the whole time reset is held, not only
    // after the first reset edge.
    assign in_ready  = rst_n & w_adv[0];
    assign out_valid = rst_n & w_vld_q;
    assign sum       = rst_n ? w_sum_q : '0;
    assign carry_out = rst_n & w_cout_q;
`ifdef CLA_OVF_EN
    assign overflow  = rst_n & w_ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cla_pipe_adder
//  Purpose  : Self-checking bench for cla_pipe_adder (WIDTH=32, BLOCK=8).
//             Directed steps plus randomized traffic, compared against an
//             arithmetic reference model and an in-order expectation queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_adder;

    localparam int WIDTH  = 32;
    localparam int BLOCK  = 8;
    localparam int STAGES = WIDTH / BLOCK;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              carry_start;
    logic              sub;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  sum;
    logic              carry_out;
`ifdef CLA_OVF_EN
    logic              overflow;
`endif

    always #5 clk = ~clk;

    cla_pipe_adder #(
        .WIDTH (WIDTH),
        .BLOCK (BLOCK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .carry_start (carry_start),
        .sub         (sub),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sum         (sum),
        .carry_out   (carry_out)
`ifdef CLA_OVF_EN
        ,
        .overflow    (overflow)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_acc  = 0;
    int base;
    bit lat_chk   = 1'b0;
    bit hold_pend = 1'b0;
    logic [WIDTH-1:0] held_sum;
    logic             held_cout;
    logic             held_ovf;

    logic [WIDTH-1:0] q_sum [$];
    logic             q_cout[$];
    logic             q_ovf [$];
    int               q_cyc [$];

    // Reference: plain integer arithmetic. Subtraction: difference modulo
    // 2^WIDTH, carry_out = no borrow (a >= b). Overflow = the true signed
    // result does not fit in WIDTH bits. Returns {ovf, cout, sum}.
    function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic ci,
                                                 input logic s);
        logic [WIDTH:0] full;
        longint         sr;
        logic           ov;
        if (s) begin
            full[WIDTH-1:0] = x - y;
            full[WIDTH]     = (x >= y);
            sr = longint'($signed(x)) - longint'($signed(y));
        end else begin
            full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
            sr = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
        end
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {ov, full};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the rising edge, sample and
    // score at the falling edge, then move to just after the next rising edge.
    task automatic drive_cycle(input logic v, input logic [WIDTH-1:0] aa,
                               input logic [WIDTH-1:0] bb, input logic cc,
                               input logic ss, input logic ordy);
        logic [WIDTH+1:0] r;
        in_valid    = v;
        a           = aa;
        b           = bb;
        carry_start = cc;
        sub         = ss;
        out_ready   = ordy;
        @(negedge clk);
        if (hold_pend) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_sum", sum, held_sum);
            check("hold_cout", carry_out, held_cout);
`ifdef CLA_OVF_EN
            check("hold_ovf", overflow, held_ovf);
`endif
        end
        // Input is blocked only when every stage holds an operation and the
        // output is stalled.
        check("in_ready", in_ready, !(q_sum.size() == STAGES && !out_ready));
        if (q_sum.size() == 0) begin
            check("idle_valid", out_valid, 1'b0);
        end else if (out_valid && out_ready) begin
            check("sum", sum, q_sum.pop_front());
            check("carry_out", carry_out, q_cout.pop_front());
`ifdef CLA_OVF_EN
            check("overflow", overflow, q_ovf.pop_front());
`else
            void'(q_ovf.pop_front());
`endif
            if (lat_chk) check("latency", cyc - q_cyc[0], STAGES);
            void'(q_cyc.pop_front());
        end
        hold_pend = out_valid && !out_ready;
        held_sum  = sum;
        held_cout = carry_out;
`ifdef CLA_OVF_EN
        held_ovf  = overflow;
`else
        held_ovf  = 1'b0;
`endif
        if (in_valid && in_ready) begin
            r = ref_add(a, b, carry_start, sub);
            q_sum.push_back(r[WIDTH-1:0]);
            q_cout.push_back(r[WIDTH]);
            q_ovf.push_back(r[WIDTH+1]);
            q_cyc.push_back(cyc);
            n_acc++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++)
            drive_cycle(1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom), ordy);
    endtask

    initial begin
        // ---- reset state ----
        rst_n = 1'b0; in_valid = 1'b1; a = '1; b = '1;
        carry_start = 1'b1; sub = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_sum", sum, '0);
        check("rst_carry_out", carry_out, 1'b0);
`ifdef CLA_OVF_EN
        check("rst_overflow", overflow, 1'b0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1'b1);
        @(posedge clk); #1;

        // ---- directed: carry through all blocks, subtraction both ways ----
        lat_chk = 1'b1;
        drive_cycle(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        idle(5, 1'b1);
        drive_cycle(1'b1, 32'd5, 32'd7, 1'b0, 1'b1, 1'b1);
        drive_cycle(1'b1, 32'd7, 32'd5, 1'b1, 1'b1, 1'b1);
        drive_cycle(1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b1);
`ifdef CLA_OVF_EN
        drive_cycle(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
`endif
        idle(6, 1'b1);

        // ---- 8 back-to-back operations, no backpressure ----
        base = n_acc;
        for (int i = 0; i < 8; i++)
            drive_cycle(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
        check("b2b_accepts", n_acc - base, 8);
        idle(6, 1'b1);

        // ---- stall output for 6 cycles while streaming ----
        lat_chk = 1'b0;
        base = n_acc;
        for (int i = 0; i < 6; i++)
            drive_cycle(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0);
        check("stall_accepts", n_acc - base, STAGES);
        for (int i = 0; i < 4; i++)
            drive_cycle(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
        idle(8, 1'b1);
        check("drain1_empty", q_sum.size(), 0);

        // ---- reset with 3 operations in flight ----
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
        rst_n = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        check("rst2_out_valid", out_valid, 1'b0);
        check("rst2_in_ready", in_ready, 1'b0);
        check("rst2_sum", sum, '0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        rst_n = 1'b1; in_valid = 1'b0;
        q_sum.delete(); q_cout.delete(); q_ovf.delete(); q_cyc.delete();
        hold_pend = 1'b0;
        cyc++;
        @(negedge clk);
        check("in_ready_after_rst2", in_ready, 1'b1);
        check("flushed_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        cyc++;
        idle(8, 1'b1);

        // ---- random traffic with random backpressure ----
        for (int i = 0; i < 300; i++)
            drive_cycle(1'($urandom_range(0, 9) < 7), $urandom, $urandom,
                        1'($urandom), 1'($urandom), 1'($urandom_range(0, 9) < 6));
        for (int i = 0; i < 40 && q_sum.size() > 0; i++)
            idle(1, 1'b1);
        check("drain2_empty", q_sum.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and sum width in bits.
REQ-002 SHALL have parameter BLOCK, default 8, carry-lookahead block width in bits; WIDTH SHALL be an integer multiple of BLOCK; STAGES = WIDTH/BLOCK.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operand set present.
REQ-006 SHALL have port in_ready  output  1  block accepts the operand set this cycle.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port carry_start  input  1  carry into bit 0; ignored when sub=1.
REQ-010 SHALL have port sub  input  1  0 = a+b+carry_start; 1 = a-b, i.e. a+~b+1.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  downstream takes the result.
REQ-013 SHALL have port sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 SHALL have port carry_out  output  1  carry out of bit WIDTH-1; for sub, 1 means no borrow.
REQ-015 SHALL have port overflow  output  1  signed overflow; present only under CLA_OVF_EN.

Function
REQ-016 SHALL be pipelined into STAGES stages; stage k computes bits [k*BLOCK +: BLOCK] with a BLOCK-bit lookahead unit, using the registered carry from stage k-1 (stage 0 uses carry_start, or 1 when sub=1).
REQ-017 SHALL carry the unprocessed upper operand bits and the completed lower sum bits forward in per-stage registers, each with a valid bit.
REQ-018 SHALL accept an operand set on a cycle with in_valid=1 and in_ready=1, and SHALL present its result with out_valid=1 exactly STAGES cycles later when there is no backpressure.
REQ-019 SHALL sustain one accepted operation per cycle while out_ready=1.
REQ-020 SHALL advance stage k when stage k is empty or stage k+1 advances; the last stage advances when out_ready=1 or out_valid=0.
REQ-021 SHALL drive in_ready=1 when stage 0 is empty or stage 0 advances, so bubbles collapse.
REQ-022 SHALL hold sum, carry_out, overflow and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL never drop, duplicate or reorder operations; results leave in acceptance order.
REQ-024 SHALL accept a new set and retire a result in the same cycle when both handshakes complete.
REQ-025 SHALL ignore a, b, carry_start and sub on cycles without an accept.
REQ-026 With STAGES=1, SHALL behave as a single registered adder with 1-cycle latency.

Reset
REQ-027 SHALL clear all stage valid bits to 0 on a clk edge with rst_n=0; an operation in flight SHALL be discarded without ever being output.
REQ-028 SHALL drive out_valid=0, sum=0, carry_out=0, overflow=0 and in_ready=0 while rst_n=0.
REQ-029 SHALL drive in_ready=1 on the first cycle after rst_n returns to 1.

Configuration
REQ-030 With macro CLA_OVF_EN defined, SHALL provide port overflow = carry into bit WIDTH-1 XOR carry_out, registered and aligned with sum.
REQ-031 Without CLA_OVF_EN, SHALL omit port overflow and its pipeline register; all other behaviour SHALL be identical.

Verification
REQ-032 Set WIDTH=32, BLOCK=8. Send a=0xFFFFFFFF, b=0x00000000, carry_start=1, sub=0 -> 4 cycles later sum=0x00000000, carry_out=1.
REQ-033 Send a=5, b=7, sub=1 -> sum=0xFFFFFFFE, carry_out=0. Send a=7, b=5, sub=1 -> sum=0x00000002, carry_out=1.
REQ-034 Send 8 back-to-back operations with out_ready=1 -> 8 consecutive out_valid cycles starting at cycle 4; results in order and equal to the reference model.
REQ-035 Hold out_ready=0 for 6 cycles while streaming -> in_ready falls after 4 accepts, outputs stay stable, and all results appear in order once out_ready=1.
REQ-036 Drop rst_n for 1 cycle with 3 operations in flight -> no out_valid for them afterwards; in_ready=1 on the next cycle.
REQ-037 With CLA_OVF_EN defined, send a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, overflow=1, carry_out=0; send a=0x80000000, b=1, sub=1 -> overflow=1.
